// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_pipe multiply-accumulate engine.
package mac_pkg;

  localparam int CNT_W     = 16;
  // Operands travel through S1 extended to this width so the stage record
  // can live in the package independent of A_W/B_W.
  localparam int OPD_MAX_W = 32;

  typedef enum logic [1:0] {
    OP_MAC  = 2'b00,
    OP_MSUB = 2'b01,
    OP_LOAD = 2'b10,
    OP_RSVD = 2'b11
  } mac_op_e;

  typedef struct packed {
    logic [OPD_MAX_W-1:0] a;
    logic [OPD_MAX_W-1:0] b;
    mac_op_e              op;
    logic                 last;
    logic                 valid;
  } mac_stage_t;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/mac_pipe_sat_add.sv
// Add/subtract with overflow detect and optional clamping; combinational.
module mac_sat_add #(
  parameter int ACC_W  = 40,
  parameter bit SIGNED = 1'b1,
  parameter bit SAT    = 1'b1
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             sub,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam int MSB = ACC_W - 1;

  logic [ACC_W:0]   raw;
  logic [ACC_W-1:0] clamp;

  always_comb begin
    raw = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    if (SIGNED) begin
      // a and the effective addend agree in sign but the result does not
      ovf   = sub ? ((a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]))
                  : ((a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]));
      clamp = a[MSB] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      // bit ACC_W is the carry on add and the borrow on subtract
      ovf   = raw[ACC_W];
      clamp = sub ? '0 : '1;
    end
    sum = (SAT && ovf) ? clamp : raw[ACC_W-1:0];
  end

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate: S1 operand regs, S2 product, S3 accumulator,
// then a result register; the whole pipe stalls together on output backpressure.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int ACC_W  = 40,
  parameter bit SIGNED = 1'b1,
  parameter bit SAT    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int STAGES = 3;

  if (ACC_W < A_W + B_W) begin : g_bad_acc_w
    $error("mac_pipe: ACC_W must be >= A_W+B_W");
  end
  if (A_W > OPD_MAX_W || B_W > OPD_MAX_W) begin : g_bad_opd_w
    $error("mac_pipe: operand width exceeds OPD_MAX_W");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1 valid rides in s1_q; vld_pipe carries S2 and S3 slot valids.
  mac_stage_t          s_in, s1_q;
  logic [STAGES:2]     vld_pipe;
  logic [ACC_W-1:0]    a_x, b_x, prod;
  logic [ACC_W-1:0]    p2_q;
  mac_op_e             op2_q;
  logic                last2_q, last3_q;

  logic [ACC_W-1:0]    acc_q, acc_d, base_acc, add_sum;
  logic                ovf_q, ovf_d, base_ovf, add_ovf;
  logic [CNT_W-1:0]    cnt_q, cnt_d, base_cnt;
  logic                frame_end;

  always_comb begin
    s_in.a     = SIGNED ? OPD_MAX_W'($signed(in_a)) : OPD_MAX_W'(in_a);
    s_in.b     = SIGNED ? OPD_MAX_W'($signed(in_b)) : OPD_MAX_W'(in_b);
    s_in.op    = mac_op_e'(in_op);
    s_in.last  = in_last;
    s_in.valid = in_valid && adv;
  end

  // Operands are already extended, so the low ACC_W bits of the product are exact.
  always_comb begin
    a_x  = SIGNED ? ACC_W'($signed(s1_q.a)) : ACC_W'(s1_q.a);
    b_x  = SIGNED ? ACC_W'($signed(s1_q.b)) : ACC_W'(s1_q.b);
    prod = a_x * b_x;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      vld_pipe <= '0;
      p2_q     <= '0;
      op2_q    <= OP_MAC;
      last2_q  <= 1'b0;
    end else if (adv) begin
      s1_q     <= s_in;
      vld_pipe <= {vld_pipe[STAGES-1:2], s1_q.valid};
      p2_q     <= prod;
      op2_q    <= s1_q.op;
      last2_q  <= s1_q.last;
    end
  end

  // A frame that just closed in S3 hands the next term a zeroed accumulator.
  always_comb begin
    frame_end = vld_pipe[STAGES] && last3_q;
    base_acc  = frame_end ? '0   : acc_q;
    base_ovf  = frame_end ? 1'b0 : ovf_q;
    base_cnt  = frame_end ? '0   : cnt_q;
  end

  mac_sat_add #(
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_add (
    .a   (base_acc),
    .b   (p2_q),
    .sub (op2_q == OP_MSUB),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    acc_d = base_acc;
    ovf_d = base_ovf;
    cnt_d = base_cnt;
    if (vld_pipe[2]) begin
      if (op2_q == OP_LOAD) begin
        acc_d = p2_q;
        ovf_d = 1'b0;
        cnt_d = CNT_W'(1);
      end else begin
        acc_d = add_sum;
        ovf_d = base_ovf | add_ovf;
        cnt_d = cnt_inc(base_cnt);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      last3_q <= 1'b0;
    end else if (adv) begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      last3_q <= last2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else if (adv) begin
      out_valid <= frame_end;
      if (frame_end) begin
        out_acc <= acc_q;
        out_ovf <= ovf_q;
        out_cnt <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench: four mac_pipe variants share one stimulus stream; results are
// collected per variant at handshake time and checked against hand values.
module tb_mac_pipe;
  import mac_pkg::*;

  typedef struct {
    logic [63:0] acc;
    logic        ovf;
    int          cnt;
    int          cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [15:0] in_a = '0, in_b = '0;
  logic [1:0]  in_op = '0;

  logic        m_in_ready, m_out_valid, m_out_ovf;
  logic [39:0] m_out_acc;
  logic [15:0] m_out_cnt;
  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [31:0] s_out_acc;
  logic [15:0] s_out_cnt;
  logic        w_in_ready, w_out_valid, w_out_ovf;
  logic [31:0] w_out_acc;
  logic [15:0] w_out_cnt;
  logic        u_in_ready, u_out_valid, u_out_ovf;
  logic [39:0] u_out_acc;
  logic [15:0] u_out_cnt;

  int   n_chk = 0, n_err = 0;
  int   ncyc = 0, last_acc = 0;
  res_t qm[$], qs[$], qw[$], qu[$];

  always #5 clk = ~clk;

  mac_pipe #(.A_W(16), .B_W(16), .ACC_W(40), .SIGNED(1'b1), .SAT(1'b1)) u_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_acc(m_out_acc),
    .out_ovf(m_out_ovf), .out_cnt(m_out_cnt));

  mac_pipe #(.A_W(16), .B_W(16), .ACC_W(32), .SIGNED(1'b1), .SAT(1'b1)) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc),
    .out_ovf(s_out_ovf), .out_cnt(s_out_cnt));

  mac_pipe #(.A_W(16), .B_W(16), .ACC_W(32), .SIGNED(1'b1), .SAT(1'b0)) u_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_acc(w_out_acc),
    .out_ovf(w_out_ovf), .out_cnt(w_out_cnt));

  mac_pipe #(.A_W(16), .B_W(16), .ACC_W(40), .SIGNED(1'b0), .SAT(1'b1)) u_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_acc(u_out_acc),
    .out_ovf(u_out_ovf), .out_cnt(u_out_cnt));

  always @(negedge clk) ncyc <= ncyc + 1;

  function automatic res_t mk(input logic [63:0] acc, input logic ovf, input logic [15:0] cnt);
    res_t r;
    r.acc = acc; r.ovf = ovf; r.cnt = int'(cnt); r.cyc = ncyc;
    return r;
  endfunction

  // Results are logged mid-low-phase, after the bench has settled out_ready.
  always @(negedge clk) begin
    #2;
    if (out_ready) begin
      if (m_out_valid) qm.push_back(mk(64'(m_out_acc), m_out_ovf, m_out_cnt));
      if (s_out_valid) qs.push_back(mk(64'(s_out_acc), s_out_ovf, s_out_cnt));
      if (w_out_valid) qw.push_back(mk(64'(w_out_acc), w_out_ovf, w_out_cnt));
      if (u_out_valid) qu.push_back(mk(64'(u_out_acc), u_out_ovf, u_out_cnt));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] msk(input longint v, input int w);
    logic [63:0] m;
    m = (64'h1 << w) - 64'h1;
    return 64'(v) & m;
  endfunction

  function automatic int qsz(input int sel);
    case (sel)
      0: return qm.size();
      1: return qs.size();
      2: return qw.size();
      default: return qu.size();
    endcase
  endfunction

  task automatic flush();
    qm.delete(); qs.delete(); qw.delete(); qu.delete();
  endtask

  task automatic put(input int a, input int b, input int op, input bit last);
    int t;
    @(negedge clk); #1;
    in_valid = 1'b1; in_a = 16'(a); in_b = 16'(b); in_op = 2'(op); in_last = last;
    t = 0;
    while (!m_in_ready && t < 100) begin @(negedge clk); #1; t++; end
    if (!m_in_ready) chk("put_ready_timeout", 64'(m_in_ready), 64'd1);
    last_acc = ncyc;
  endtask

  task automatic idle();
    @(negedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pop(input int sel, output res_t r);
    int t;
    t = 0;
    r.acc = '0; r.ovf = 1'b0; r.cnt = -1; r.cyc = 0;
    while (qsz(sel) == 0 && t < 300) begin @(negedge clk); #1; t++; end
    if (qsz(sel) == 0) chk($sformatf("pop%0d_timeout", sel), 64'(qsz(sel)), 64'd1);
    else case (sel)
      0: r = qm.pop_front();
      1: r = qs.pop_front();
      2: r = qw.pop_front();
      default: r = qu.pop_front();
    endcase
  endtask

  task automatic chk_res(input string tag, input int sel, input logic [63:0] acc,
                         input logic ovf, input int cnt, output res_t r);
    pop(sel, r);
    chk({tag, "_acc"}, r.acc, acc);
    chk({tag, "_ovf"}, 64'(r.ovf), 64'(ovf));
    chk({tag, "_cnt"}, 64'(r.cnt), 64'(cnt));
  endtask

  initial begin
    res_t r, ra;
    int   bad;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(m_out_valid), 64'd0);
    chk("rst_out_acc",   64'(m_out_acc),   64'd0);
    chk("rst_out_ovf",   64'(m_out_ovf),   64'd0);
    chk("rst_out_cnt",   64'(m_out_cnt),   64'd0);
    chk("rst_in_ready",  64'(m_in_ready),  64'd1);
    rst = 1'b0;

    // 12 - 10 - 7 = -5; third op is the reserved code, which accumulates like MAC
    flush();
    put(3, 4, 0, 1'b0);
    put(-2, 5, 0, 1'b0);
    put(7, -1, 3, 1'b1);
    idle();
    chk_res("mac3", 0, msk(-5, 40), 1'b0, 3, r);
    // accept edge follows negedge last_acc; result visible 4 negedges later (edge k+3)
    chk("mac3_latency", 64'(r.cyc - last_acc), 64'd4);

    flush();
    put(10, 10, 2, 1'b0);
    put(3, 3, 1, 1'b1);
    idle();
    chk_res("load_msub", 0, 64'd91, 1'b0, 2, r);

    // five 2^30 terms: 32-bit saturates, 32-bit wrap lands on 5*2^30 mod 2^32
    flush();
    for (int i = 0; i < 5; i++) put(-32768, -32768, 0, i == 4);
    idle();
    chk_res("sat32",  1, 64'h7FFF_FFFF, 1'b1, 5, r);
    chk_res("wrap32", 2, 64'h4000_0000, 1'b1, 5, r);
    chk_res("wide40", 0, 64'h1_4000_0000, 1'b0, 5, r);

    flush();
    put(0, 0, 0, 1'b0);
    put(1, 1, 1, 1'b1);
    idle();
    chk_res("uns_borrow", 3, 64'd0, 1'b1, 2, r);
    chk_res("sgn_neg1",   0, msk(-1, 40), 1'b0, 2, r);

    // stall with four single-term frames in flight and a fifth held at the input
    flush();
    out_ready = 1'b0;
    put(2, 3, 2, 1'b1);
    put(4, 5, 2, 1'b1);
    put(6, 7, 2, 1'b1);
    put(1, 9, 2, 1'b1);
    @(negedge clk); #1;
    in_valid = 1'b1; in_a = 16'd2; in_b = 16'd2; in_op = 2'd2; in_last = 1'b1;
    chk("stall_acc", 64'(m_out_acc), 64'd6);
    bad = 0;
    repeat (10) begin
      if (m_in_ready || s_in_ready || w_in_ready || u_in_ready || !m_out_valid ||
          m_out_acc != 40'd6 || m_out_cnt != 16'd1 || m_out_ovf) bad++;
      @(negedge clk); #1;
    end
    chk("stall_bad_cycles", 64'(bad), 64'd0);
    chk("stall_no_emit", 64'(qsz(0)), 64'd0);
    out_ready = 1'b1;
    idle();
    chk_res("bp_a", 0, 64'd6,  1'b0, 1, ra);
    chk_res("bp_b", 0, 64'd20, 1'b0, 1, r);
    chk_res("bp_c", 0, 64'd42, 1'b0, 1, r);
    chk_res("bp_d", 0, 64'd9,  1'b0, 1, r);
    chk_res("bp_e", 0, 64'd4,  1'b0, 1, r);
    chk("bp_span", 64'(r.cyc - ra.cyc), 64'd4);

    // reset with two terms in flight: nothing may emerge
    flush();
    put(1, 1, 0, 1'b0);
    put(2, 2, 0, 1'b0);
    @(negedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("rst_mid_no_emit", 64'(qsz(0)), 64'd0);
    chk("rst_mid_out_valid", 64'(m_out_valid), 64'd0);
    put(2, 2, 0, 1'b1);
    idle();
    chk_res("post_rst", 0, 64'd4, 1'b0, 1, r);

    // 65537 terms: count pins at 65535 while acc keeps summing
    flush();
    for (int i = 0; i < 65537; i++) put(1, 1, 0, i == 65536);
    idle();
    chk_res("cnt_sat", 0, 64'd65537, 1'b0, 65535, r);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
